uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver for the UART link; it consumes the TX_OUT line of the UART transmitter.
- Oversamples RX_IN at PRESCALE clocks per bit and recovers start / data / optional parity / stop fields, LSB first, same frame format as the transmitter.
- Presents each received word on P_DATA with a one-cycle Data_Valid pulse, plus parity and framing error flags.
- Sits at the link boundary, feeding the system-side consumer (register file / FIFO writer).

## Interface
Parameters:
- DATA_WIDTH, 8, data bits per frame
- PRESCALE, 8, clocks per bit; even, ≥ 4

Ports:
- clk  in  1  receiver clock = PRESCALE × bit rate
- reset_n  in  1  asynchronous, active-low reset
- RX_IN  in  1  serial line, idle high, asynchronous to clk
- PAR_EN  in  1  1 = frame carries a parity bit
- PAR_TYP  in  1  0 = even, 1 = odd
- P_DATA  out  DATA_WIDTH  last received word, held until the next valid frame
- Data_Valid  out  1  one-cycle pulse, frame received without error
- PAR_ERR  out  1  one-cycle pulse, parity mismatch
- STP_ERR  out  1  one-cycle pulse, stop bit sampled low
- busy  out  1  high from the start-bit detect until the return to IDLE

## Operation
- **Input synchroniser:** RX_IN passes through a 2-flop synchroniser (reset value 1). All logic uses the synchronised value rx_s.
- **Counters:**
  - edge_cnt runs 0..PRESCALE-1 within each bit.
  - bit_cnt counts data bits 0..DATA_WIDTH-1.
- **Sampling:** majority vote of rx_s at edge_cnt = PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1. The vote result is available at edge_cnt = PRESCALE/2+1, the "decision edge".
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE: when rx_s = 0, go to START with edge_cnt = 0 and latch PAR_EN/PAR_TYP. Config changes mid-frame are ignored.
  - START: if the vote = 1 at the decision edge, treat it as a glitch and return to IDLE with no outputs. Otherwise go to DATA at edge_cnt = PRESCALE-1.
  - DATA: shift the vote into a shift register LSB first. After DATA_WIDTH bits, go to PARITY if PAR_EN, else STOP, at edge_cnt = PRESCALE-1.
  - PARITY: compare the vote with ^data XOR PAR_TYP, then go to STOP.
  - STOP: at the decision edge, evaluate and go to IDLE immediately, so the next start edge is caught without waiting for the bit end.
- **Frame result** (registered, visible in the cycle after the stop decision edge):
  - stop = 1 and no parity error: P_DATA <= shift register, Data_Valid = 1.
  - Otherwise: P_DATA is unchanged, Data_Valid = 0, PAR_ERR and/or STP_ERR = 1. Both flags may assert together.

## Timing
- **Reset values:** P_DATA = 0, Data_Valid = 0, PAR_ERR = 0, STP_ERR = 0, busy = 0, state IDLE, synchroniser = 1.
- **Reset mid-frame:** takes effect asynchronously; the partial frame is discarded with no pulses.
- **Latency** is counted from the first clk edge that samples RX_IN low to Data_Valid high:
  - 2 + (1 + DATA_WIDTH + PAR_EN)·PRESCALE + PRESCALE/2 + 2 cycles.
  - PRESCALE=8, 8N1: 80 cycles. 8E1: 88 cycles.
- Output pulses are exactly 1 cycle wide.
- There is no back-pressure: the consumer must take P_DATA on the Data_Valid cycle or read it before the next frame completes.
- **Back-to-back frames:** a start bit arriving immediately after a stop bit (zero idle time) must be received correctly.

## Structure
- **Shared package uart_pkg:**
  - FSM state enum.
  - Parity-type constants PAR_EVEN = 0, PAR_ODD = 1.
  - Shared with the transmitter.
- **Sub-module uart_rx_sampler:**
  - Contains edge_cnt, the three-sample majority vote and the decision-edge strobe.
  - The top level holds the FSM, bit_cnt, shift register, parity check and output registers.

## Test plan
- **Reset:** assert reset_n mid-idle and mid-frame → all outputs 0, busy 0. A fresh 0x55 frame afterwards is received.
- **8N1:** send 0xD3 with PAR_EN=0 → P_DATA = 0xD3 and Data_Valid pulses once, 80 cycles after the start edge. No error flags.
- **Parity, even and odd:**
  - Even parity with 0xD2 (parity bit 0) → Data_Valid.
  - Odd parity with 0xFB (parity bit 0) → Data_Valid.
  - Flip the parity bit → PAR_ERR pulse, no Data_Valid, P_DATA keeps its previous value.
- **Stop error:** send 0xA5 with the stop bit driven low → STP_ERR pulse, no Data_Valid.
- **Glitch:** a 2-clock low pulse on an idle line → returns to IDLE, no outputs. A single-clock spike inside a data bit, away from the sample window, does not corrupt 0x3C.
- **Back-to-back:** send 0x01, 0x80, 0xFF with no idle gap → three Data_Valid pulses with the correct values, 80 cycles apart.

Source files
------------

// File: rtl/uart_pkg.sv
// Types and constants shared by the UART transmitter and receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit oversampling counter with a three-sample majority vote around mid-bit.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESCALE = 8
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic run_i,
    input  logic rx_i,
    output logic vote_o,
    output logic decide_o,
    output logic bit_end_o
);
    localparam int CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] CNT_S0   = CW'(PRESCALE / 2 - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(PRESCALE / 2);
    localparam logic [CW-1:0] CNT_S2   = CW'(PRESCALE / 2 + 1);

    logic [CW-1:0] edge_cnt_q, edge_cnt_d;
    logic          s0_q, s1_q;

    // Held at zero while idle so a new start bit always begins a fresh bit period.
    always_comb begin
        edge_cnt_d = '0;
        if (run_i && (edge_cnt_q != CNT_LAST)) begin
            edge_cnt_d = edge_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            edge_cnt_q <= '0;
            s0_q       <= 1'b1;
            s1_q       <= 1'b1;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            if (edge_cnt_q == CNT_S0) s0_q <= rx_i;
            if (edge_cnt_q == CNT_S1) s1_q <= rx_i;
        end
    end

    // Third sample is taken live, so the vote is ready on the decision edge itself.
    assign vote_o    = maj3(s0_q, s1_q, rx_i);
    assign decide_o  = run_i && (edge_cnt_q == CNT_S2);
    assign bit_end_o = run_i && (edge_cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchroniser, frame FSM, shift register, parity/stop checks.
// state  | meaning
// IDLE   | line high, waiting for a falling edge
// START  | confirming the start bit; high vote is a glitch
// DATA   | shifting DATA_WIDTH bits in, LSB first
// PARITY | comparing the parity bit against the shifted word
// STOP   | sampling the stop bit, then reporting the frame result
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE   = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  PAR_ERR,
    output logic                  STP_ERR,
    output logic                  busy
);
    localparam int BCW = $clog2(DATA_WIDTH + 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_WIDTH - 1);

    logic [1:0]            sync_q;
    logic                  rx_s;
    uart_state_e           state_q;
    logic [BCW-1:0]        bit_cnt_q;
    logic [DATA_WIDTH-1:0] shreg_q;
    logic                  par_en_q, par_typ_q, par_bad_q;
    logic                  vote, decide, bit_end;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= 2'b11;
        else          sync_q <= {sync_q[0], RX_IN};
    end
    assign rx_s = sync_q[1];

    uart_rx_sampler #(.PRESCALE(PRESCALE)) u_sampler (
        .clk_i     (clk),
        .rst_n_i   (reset_n),
        .run_i     (state_q != ST_IDLE),
        .rx_i      (rx_s),
        .vote_o    (vote),
        .decide_o  (decide),
        .bit_end_o (bit_end)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= PAR_EVEN;
            par_bad_q  <= 1'b0;
            P_DATA     <= '0;
            Data_Valid <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            Data_Valid <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_q   <= ST_START;
                        busy      <= 1'b1;
                        par_en_q  <= PAR_EN;
                        par_typ_q <= PAR_TYP;
                        par_bad_q <= 1'b0;
                        bit_cnt_q <= '0;
                    end
                end
                ST_START: begin
                    if (decide && vote) begin
                        state_q <= ST_IDLE;
                        busy    <= 1'b0;
                    end else if (bit_end) begin
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (decide) shreg_q <= {vote, shreg_q[DATA_WIDTH-1:1]};
                    if (bit_end) begin
                        if (bit_cnt_q == BIT_LAST) state_q <= par_en_q ? ST_PARITY : ST_STOP;
                        else                       bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (decide) par_bad_q <= vote ^ (^shreg_q) ^ (par_typ_q == PAR_ODD);
                    if (bit_end) state_q <= ST_STOP;
                end
                ST_STOP: begin
                    // Leave at mid-stop so a start bit with zero idle time is still caught.
                    if (decide) begin
                        state_q <= ST_IDLE;
                        busy    <= 1'b0;
                        if (vote && !par_bad_q) begin
                            P_DATA     <= shreg_q;
                            Data_Valid <= 1'b1;
                        end else begin
                            PAR_ERR <= par_bad_q;
                            STP_ERR <= !vote;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed and random frames against a frame-level reference model of the receiver.
module tb_uart_rx;
    localparam int DW = 8;
    localparam int P  = 8;

    logic          clk, reset_n, RX_IN, PAR_EN, PAR_TYP;
    logic [DW-1:0] P_DATA;
    logic          Data_Valid, PAR_ERR, STP_ERR, busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int dv_cnt = 0, pe_cnt = 0, se_cnt = 0;
    int dv_cyc_q[$];
    logic [DW-1:0] dv_data_q[$];
    logic [DW-1:0] exp_pdata = '0;
    int start_cyc;

    uart_rx #(.DATA_WIDTH(DW), .PRESCALE(P)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_ERR    (PAR_ERR),
        .STP_ERR    (STP_ERR),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (Data_Valid) begin
            dv_cnt <= dv_cnt + 1;
            dv_cyc_q.push_back(cyc);
            dv_data_q.push_back(P_DATA);
        end
        if (PAR_ERR) pe_cnt <= pe_cnt + 1;
        if (STP_ERR) se_cnt <= se_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; holds the line for one bit period, optionally with a
    // one-clock inverted spike at the second clock of the bit (far from mid-bit).
    task automatic drive_bit(input logic b, input logic spike);
        RX_IN = b;
        if (spike) begin
            @(posedge clk); #1;
            RX_IN = ~b;
            @(posedge clk); #1;
            RX_IN = b;
            repeat (P - 2) @(posedge clk);
        end else begin
            repeat (P) @(posedge clk);
        end
        #1;
    endtask

    task automatic send_frame(input logic [DW-1:0] data, input logic pen, input logic ptyp,
                              input logic flip, input logic stop_val, input int spike_bit);
        PAR_EN    = pen;
        PAR_TYP   = ptyp;
        start_cyc = cyc;
        drive_bit(1'b0, 1'b0);
        PAR_EN  = 1'($urandom);
        PAR_TYP = 1'($urandom);
        for (int i = 0; i < DW; i++) drive_bit(data[i], spike_bit == i);
        if (pen) drive_bit((^data) ^ ptyp ^ flip, 1'b0);
        drive_bit(stop_val, 1'b0);
    endtask

    task automatic run_frame(input string tag, input logic [DW-1:0] data, input logic pen,
                             input logic ptyp, input logic flip, input logic stop_val,
                             input int spike_bit);
        int dv0, pe0, se0, lat;
        logic exp_pe, exp_se, exp_dv;
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        send_frame(data, pen, ptyp, flip, stop_val, spike_bit);
        RX_IN = 1'b1;
        repeat (2 * P) @(posedge clk);
        #1;
        exp_pe = pen && flip;
        exp_se = !stop_val;
        exp_dv = !exp_pe && !exp_se;
        if (exp_dv) exp_pdata = data;
        check({tag, " dv_pulses"},  32'(dv_cnt - dv0), 32'(exp_dv));
        check({tag, " par_pulses"}, 32'(pe_cnt - pe0), 32'(exp_pe));
        check({tag, " stp_pulses"}, 32'(se_cnt - se0), 32'(exp_se));
        check({tag, " p_data"},     32'(P_DATA), 32'(exp_pdata));
        check({tag, " busy_idle"},  32'(busy), 32'(0));
        if (exp_dv && dv_cnt == dv0 + 1) begin
            lat = dv_cyc_q[$] - (start_cyc + 1);
            check({tag, " latency"}, 32'(lat), 32'(2 + (1 + DW + int'(pen)) * P + P / 2 + 2));
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " p_data"}, 32'(P_DATA), 32'(0));
        check({tag, " dv"},     32'(Data_Valid), 32'(0));
        check({tag, " par"},    32'(PAR_ERR), 32'(0));
        check({tag, " stp"},    32'(STP_ERR), 32'(0));
        check({tag, " busy"},   32'(busy), 32'(0));
    endtask

    initial begin
        int dv0, pe0, se0;
        logic [DW-1:0] rdata;
        logic rpen, rtyp, rflip, rstop;

        reset_n = 1'b0; RX_IN = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        #1;
        check_outputs_zero("reset");
        repeat (4) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        run_frame("8N1 d3",        8'hD3, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        run_frame("8E1 d2",        8'hD2, 1'b1, 1'b0, 1'b0, 1'b1, -1);
        run_frame("8O1 fb",        8'hFB, 1'b1, 1'b1, 1'b0, 1'b1, -1);
        run_frame("odd flip 5a",   8'h5A, 1'b1, 1'b1, 1'b1, 1'b1, -1);
        run_frame("even flip 81",  8'h81, 1'b1, 1'b0, 1'b1, 1'b1, -1);
        run_frame("stop err a5",   8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        run_frame("par+stop err",  8'h3E, 1'b1, 1'b0, 1'b1, 1'b0, -1);

        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        RX_IN = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        RX_IN = 1'b1;
        repeat (3 * P) @(posedge clk);
        #1;
        check("glitch outputs", 32'(dv_cnt - dv0 + pe_cnt - pe0 + se_cnt - se0), 32'(0));
        check("glitch busy",    32'(busy), 32'(0));
        check("glitch p_data",  32'(P_DATA), 32'(exp_pdata));

        run_frame("spike 3c", 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 3);

        dv0 = dv_cnt;
        send_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        send_frame(8'h80, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        RX_IN = 1'b1;
        repeat (2 * P) @(posedge clk);
        #1;
        check("b2b count", 32'(dv_cnt - dv0), 32'(3));
        if (dv_data_q.size() >= dv0 + 3) begin
            check("b2b data0", 32'(dv_data_q[dv0]),     32'h01);
            check("b2b data1", 32'(dv_data_q[dv0 + 1]), 32'h80);
            check("b2b data2", 32'(dv_data_q[dv0 + 2]), 32'hFF);
            check("b2b gap1",  32'(dv_cyc_q[dv0 + 1] - dv_cyc_q[dv0]),     32'(10 * P));
            check("b2b gap2",  32'(dv_cyc_q[dv0 + 2] - dv_cyc_q[dv0 + 1]), 32'(10 * P));
        end
        exp_pdata = 8'hFF;

        for (int n = 0; n < 12; n++) begin
            rdata = 8'($urandom);
            rpen  = 1'($urandom);
            rtyp  = 1'($urandom);
            rflip = ($urandom_range(0, 3) == 0);
            rstop = ($urandom_range(0, 5) != 0);
            run_frame($sformatf("rand%0d", n), rdata, rpen, rtyp, rflip, rstop, -1);
        end

        #2 reset_n = 1'b0;
        #1;
        check_outputs_zero("idle reset");
        exp_pdata = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        PAR_EN = 1'b0;
        RX_IN  = 1'b0;
        repeat (3 * P) @(posedge clk);
        #1;
        check("midframe busy", 32'(busy), 32'(1));
        #2 reset_n = 1'b0;
        #1;
        check_outputs_zero("midframe reset");
        RX_IN = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (12 * P) @(posedge clk);
        #1;
        check("midframe no pulses", 32'(dv_cnt - dv0 + pe_cnt - pe0 + se_cnt - se0), 32'(0));
        run_frame("post-reset 55", 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
